// File: rtl/cpu_pkg.sv
// Shared CPU definitions: sequencer state encoding, program-state codes and PC width.
package cpu_pkg;

  localparam int unsigned PC_W = 10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } seq_state_e;

  // Program-state codes, also decoded by the divide-by-zero exception monitor
  localparam logic [1:0] PS_IDLE = 2'b00;
  localparam logic [1:0] PS_P1   = 2'b01;
  localparam logic [1:0] PS_P2   = 2'b10;
  localparam logic [1:0] PS_P3   = 2'b11;

endpackage

// File: rtl/prog_sequencer.sv
// Program sequencer: owns PC and ProgState, runs programs 1..3 on a Start/Ack handshake.
// Optional cycle counter output enabled by defining SEQ_CYCLE_COUNT_EN.
module prog_sequencer #(
  parameter int unsigned          PC_W       = cpu_pkg::PC_W,
  parameter logic [PC_W-1:0]      PROG1_BASE = PC_W'(0),
  parameter logic [PC_W-1:0]      PROG2_BASE = PC_W'(256),
  parameter logic [PC_W-1:0]      PROG3_BASE = PC_W'(512)
) (
  input  logic            CLK,
  input  logic            RESET_N,
  input  logic            Start,
  input  logic            Halt,
  input  logic            BranchEn,
  input  logic [PC_W-1:0] Target,
  input  logic            Stall,
  output logic [PC_W-1:0] PC,
  output logic [1:0]      ProgState,
  output logic            Running,
`ifdef SEQ_CYCLE_COUNT_EN
  output logic            Ack,
  output logic [15:0]     CycleCount
`else
  output logic            Ack
`endif
);
  import cpu_pkg::*;

  seq_state_e      state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [1:0]      ps_q, ps_d;
  logic            ack_q, ack_d;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ps_d    = ps_q;
    ack_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (Start) begin
          state_d = RUN;
          ps_d    = PS_P1;
          pc_d    = PROG1_BASE;
        end
      end
      RUN: begin
        // Halt beats Stall beats BranchEn; a stalled branch is dropped
        if (Halt) begin
          state_d = DONE;
          ack_d   = 1'b1;
        end else if (!Stall) begin
          if (BranchEn) pc_d = Target;
          else          pc_d = pc_q + 1'b1;
        end
      end
      DONE: begin
        if (Start && (ps_q != PS_P3)) begin
          state_d = RUN;
          ps_d    = ps_q + 2'd1;
          pc_d    = (ps_q == PS_P1) ? PROG2_BASE : PROG3_BASE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= IDLE;
      pc_q    <= '0;
      ps_q    <= PS_IDLE;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ps_q    <= ps_d;
      ack_q   <= ack_d;
    end
  end

  assign PC        = pc_q;
  assign ProgState = ps_q;
  assign Running   = (state_q == RUN);
  assign Ack       = ack_q;

`ifdef SEQ_CYCLE_COUNT_EN
  logic [15:0] cnt_q, cnt_d;
  logic        launch;

  assign launch = (state_q != RUN) && (state_d == RUN);

  always_comb begin
    cnt_d = cnt_q;
    if (launch)                                cnt_d = '0;
    else if ((state_q == RUN) && (cnt_q != '1)) cnt_d = cnt_q + 16'd1;
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  assign CycleCount = cnt_q;
`endif

endmodule

// File: tb/tb_prog_sequencer.sv
// Self-checking bench for prog_sequencer: behavioural model feeds a scoreboard queue.
module tb_prog_sequencer;

  logic       CLK = 1'b0;
  logic       RESET_N;
  logic       Start, Halt, BranchEn, Stall;
  logic [9:0] Target;
  logic [9:0] PC;
  logic [1:0] ProgState;
  logic       Running, Ack;
`ifdef SEQ_CYCLE_COUNT_EN
  logic [15:0] CycleCount;
`endif

  prog_sequencer #(
    .PC_W       (10),
    .PROG1_BASE (10'd0),
    .PROG2_BASE (10'd256),
    .PROG3_BASE (10'd512)
  ) dut (
    .CLK        (CLK),
    .RESET_N    (RESET_N),
    .Start      (Start),
    .Halt       (Halt),
    .BranchEn   (BranchEn),
    .Target     (Target),
    .Stall      (Stall),
    .PC         (PC),
    .ProgState  (ProgState),
    .Running    (Running),
`ifdef SEQ_CYCLE_COUNT_EN
    .Ack        (Ack),
    .CycleCount (CycleCount)
`else
    .Ack        (Ack)
`endif
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [9:0]  pc;
    logic [1:0]  ps;
    logic        run;
    logic        ack;
    logic [15:0] cnt;
  } exp_t;

  exp_t        sb_q[$];
  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  // Reference model state: 0 idle, 1 run, 2 done
  int          m_st;
  logic [9:0]  m_pc;
  logic [1:0]  m_ps;
  logic        m_ack;
  logic [15:0] m_cnt;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_st = 0; m_pc = 10'd0; m_ps = 2'd0; m_ack = 1'b0; m_cnt = 16'd0;
  endtask

  task automatic model_advance(input logic st, input logic h, input logic b,
                               input logic [9:0] t, input logic s);
    m_ack = 1'b0;
    case (m_st)
      0: if (st) begin m_st = 1; m_ps = 2'd1; m_pc = 10'd0; m_cnt = 16'd0; end
      1: begin
        if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
        if (h) begin m_st = 2; m_ack = 1'b1; end
        else if (s) m_pc = m_pc;
        else if (b) m_pc = t;
        else m_pc = m_pc + 10'd1;
      end
      default: if (st && m_ps != 2'd3) begin
        m_st  = 1;
        m_ps  = m_ps + 2'd1;
        m_pc  = (m_ps == 2'd2) ? 10'd256 : 10'd512;
        m_cnt = 16'd0;
      end
    endcase
  endtask

  task automatic step(input logic st, input logic h, input logic b,
                      input logic [9:0] t, input logic s);
    exp_t e;
    @(negedge CLK);
    Start = st; Halt = h; BranchEn = b; Target = t; Stall = s;
    model_advance(st, h, b, t, s);
    e = '{pc: m_pc, ps: m_ps, run: (m_st == 1), ack: m_ack, cnt: m_cnt};
    sb_q.push_back(e);
    @(posedge CLK);
    #1;
    e = sb_q.pop_front();
    check_val("sb_pc", PC, e.pc);
    check_val("sb_ps", ProgState, e.ps);
    check_val("sb_running", Running, e.run);
    check_val("sb_ack", Ack, e.ack);
`ifdef SEQ_CYCLE_COUNT_EN
    check_val("sb_cnt", CycleCount, e.cnt);
`endif
  endtask

  task automatic idle(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 10'd0, 1'b0);
  endtask

  task automatic release_reset();
    @(negedge CLK);
    Start = 1'b0; Halt = 1'b0; BranchEn = 1'b0; Stall = 1'b0; Target = 10'd0;
    RESET_N = 1'b1;
    model_reset();
  endtask

  task automatic async_reset_check(input string tag);
    #2 RESET_N = 1'b0;
    #1;
    check_val({tag, "_pc"}, PC, 0);
    check_val({tag, "_ps"}, ProgState, 0);
    check_val({tag, "_running"}, Running, 0);
    check_val({tag, "_ack"}, Ack, 0);
    @(posedge CLK);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    RESET_N = 1'b0; Start = 1'b1; Halt = 1'b0; BranchEn = 1'b0; Stall = 1'b0; Target = 10'd0;
    model_reset();

    for (int i = 0; i < 3; i++) begin
      @(posedge CLK);
      #1;
      check_val("rst_pc", PC, 0);
      check_val("rst_ps", ProgState, 0);
      check_val("rst_ack", Ack, 0);
      check_val("rst_running", Running, 0);
    end
    release_reset();
    idle(2);

    step(1'b1, 1'b0, 1'b0, 10'd0, 1'b0);
    check_val("p1_ps", ProgState, 1);
    check_val("p1_pc", PC, 0);
    check_val("p1_running", Running, 1);

    idle(51);
    check_val("freerun_pc", PC, 10'h033);
    step(1'b0, 1'b0, 1'b1, 10'd300, 1'b0);
    check_val("branch_pc", PC, 300);

    step(1'b0, 1'b0, 1'b1, 10'd40, 1'b0);
    step(1'b0, 1'b0, 1'b1, 10'd100, 1'b1);
    check_val("stall_branch_pc", PC, 40);
    step(1'b0, 1'b0, 1'b1, 10'd100, 1'b0);
    check_val("rebranch_pc", PC, 100);

    step(1'b0, 1'b0, 1'b1, 10'd60, 1'b0);
    step(1'b0, 1'b1, 1'b1, 10'd200, 1'b0);
    check_val("halt_pc", PC, 60);
    check_val("halt_ack", Ack, 1);
    check_val("halt_running", Running, 0);
    check_val("halt_ps", ProgState, 1);
    idle(1);
    check_val("ack_pulse_end", Ack, 0);
    step(1'b0, 1'b1, 1'b1, 10'd5, 1'b1);
    check_val("done_ignore_pc", PC, 60);

    step(1'b1, 1'b0, 1'b0, 10'd0, 1'b0);
    check_val("p2_ps", ProgState, 2);
    check_val("p2_pc", PC, 256);
    idle(5);
    step(1'b0, 1'b1, 1'b0, 10'd0, 1'b0);
    idle(1);
    step(1'b1, 1'b0, 1'b0, 10'd0, 1'b0);
    check_val("p3_ps", ProgState, 3);
    check_val("p3_pc", PC, 512);
    step(1'b1, 1'b0, 1'b0, 10'd0, 1'b0);
    check_val("start_in_run_pc", PC, 513);
    step(1'b0, 1'b1, 1'b0, 10'd0, 1'b0);
    idle(2);
    step(1'b1, 1'b0, 1'b0, 10'd0, 1'b0);
    check_val("p3_restart_running", Running, 0);
    check_val("p3_restart_ps", ProgState, 3);
    check_val("p3_restart_ack", Ack, 0);
    idle(1);

    @(negedge CLK) RESET_N = 1'b0;
    release_reset();
    step(1'b1, 1'b0, 1'b0, 10'd0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 10'd1023, 1'b0);
    check_val("wrap_pre_pc", PC, 1023);
    idle(1);
    check_val("wrap_pc", PC, 0);
    idle(3);
    async_reset_check("midrun_rst");

    release_reset();
    step(1'b1, 1'b0, 1'b0, 10'd0, 1'b0);
    idle(2);
    step(1'b0, 1'b1, 1'b0, 10'd0, 1'b0);
    check_val("pre_cancel_ack", Ack, 1);
    async_reset_check("ack_cancel");

`ifdef SEQ_CYCLE_COUNT_EN
    release_reset();
    step(1'b1, 1'b0, 1'b0, 10'd0, 1'b0);
    check_val("cnt_cleared", CycleCount, 0);
    for (int i = 0; i < 10; i++)
      step(1'b0, (i == 9), 1'b0, 10'd0, (i == 2 || i == 4 || i == 6));
    check_val("cnt_ten", CycleCount, 10);
    idle(3);
    check_val("cnt_frozen", CycleCount, 10);
`endif

    check_val("sb_empty", sb_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/prog_sequencer.md
Name: prog_sequencer

Overview:
- Upstream neighbour of the divide-by-zero exception monitor; owns the program counter and the program-state code.
- Produces PC[9:0] (drives instruction ROM and monitor) and ProgState[1:0] (monitor and decode): 00 idle, 01 program 1, 10 program 2, 11 program 3.
- Sequences the three programs on a Start/Ack handshake with the bench; applies decoder branch/halt/stall requests.

Parameters:
- PC_W, 10, program counter width
- PROG1_BASE, 10'd0, program 1 entry address
- PROG2_BASE, 10'd256, program 2 entry address
- PROG3_BASE, 10'd512, program 3 entry address

Ports:
- CLK  input  1  system clock, all state on rising edge
- RESET_N  input  1  asynchronous active-low reset
- Start  input  1  level sampled in IDLE/DONE; launches next program
- Halt  input  1  decoder: current instruction is program-done
- BranchEn  input  1  decoder: taken branch/jump this cycle
- Target  input  PC_W  absolute branch destination
- Stall  input  1  hold PC this cycle
- PC  output  PC_W  current fetch address
- ProgState  output  2  current program code
- Running  output  1  high in RUN state
- Ack  output  1  one-cycle pulse on program completion

Behaviour:
- Reset (async assert, sync release): state IDLE, PC=0, ProgState=00, Running=0, Ack=0.
- FSM states IDLE, RUN, DONE.
- IDLE, Start=1: next edge -> RUN, ProgState=01, PC=PROG1_BASE.
- DONE, Start=1, ProgState 01 or 10: -> RUN, ProgState+1, PC = base of the new program.
- DONE, Start=1, ProgState=11: ignored; stays DONE, no new Ack.
- RUN priority, highest first: Halt > Stall > BranchEn > increment.
- Halt: -> DONE, PC holds, Ack=1 for exactly the next cycle.
- Stall: PC holds; BranchEn that cycle is dropped (decoder re-presents it).
- BranchEn: PC=Target next edge.
- Otherwise: PC=PC+1, wrapping 1023 -> 0 with no flag.
- Start while RUN: ignored.
- Halt/Stall/BranchEn outside RUN: ignored.
- Running = (state==RUN), combinational from the state register.
- ProgState holds through DONE, so the monitor sees the finished program's code until the next Start.
- Latency: a control input is reflected on PC one edge later; no combinational input -> PC path.
- Reset mid-run: immediate return to reset values; any pending Ack is cancelled.

Optional Feature:
- Macro SEQ_CYCLE_COUNT_EN.
- Defined: adds output CycleCount[15:0].
  - Cleared on the Start edge.
  - +1 each RUN cycle, including stalls; saturates at 16'hFFFF.
  - Frozen in DONE; reset value 0.
- Undefined: port and counter absent; all other behaviour identical.

Decomposition:
- Shared package (cpu_pkg):
  - typedef seq_state_e {IDLE, RUN, DONE}
  - 2-bit ProgState constants PS_IDLE/PS_P1/PS_P2/PS_P3, shared with the exception monitor
  - PC_W localparam
- Single module; next-PC mux small enough to stay inline.
- Optional sub-module pc_reg (register + next-PC select); not required.

Test Plan:
- Reset with Start=1 held: PC=0, ProgState=00, Ack=0 until RESET_N rises. Then Start pulse -> next edge ProgState=01, PC=0, Running=1.
- Free-run program 1 for 51 cycles: PC=10'd51 (0x033). BranchEn=1, Target=10'd300 -> PC=300 next edge.
- Stall=1 and BranchEn=1 together at PC=40: PC stays 40. Stall=0 -> branch re-presented, taken.
- Halt=1 and BranchEn=1 together at PC=60: state DONE, PC=60, Ack high exactly one cycle, ProgState stays 01.
- Chain programs: Start -> ProgState=10, PC=256. Halt, Start -> ProgState=11, PC=512. Halt, Start -> still DONE, ProgState=11, no Ack.
- Wrap: BranchEn Target=1023, then free-run -> PC=0. RESET_N low mid-run -> PC=0, ProgState=00 asynchronously. With SEQ_CYCLE_COUNT_EN, 10 RUN cycles including 3 stalls -> CycleCount=10.
